rv32_data_memory: RTL and testbench

Data-side memory stage driven directly by the RV32I core's dm* bus. Holds a synchronous word RAM with byte-lane stores and sign/zero-extended loads, and returns load data one clock after the address so it lines up with the core's single load bubble. A small memory-mapped output port is decoded from the same bus: a 2-entry byte FIFO with a valid/ready drain handshake and sticky error flags.

---
 rtl/rv32_data_memory.sv | 178 +++++++++++++++++
 tb/tb_rv32_data_memory.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_data_memory.sv
// Data-side memory stage for the RV32I core: synchronous byte-lane RAM with
// one-cycle extended loads, plus a memory-mapped 2-entry byte output FIFO.
module rv32_data_memory #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter              INIT_FILE  = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmAddress,
    input  logic [2:0]  dmFunc3,
    input  logic        dmWrite,
    input  logic [31:0] dmDataOut,
    output logic [31:0] dmDataIn,
    output logic [7:0]  ioData,
    output logic        ioValid,
    input  logic        ioReady,
    output logic        misaligned,
    output logic        overflow
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    logic                  is_io;
    logic                  align_err;
    logic                  ram_we;
    logic                  io_we;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  status_wr;
    logic                  fifo_full;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [3:0]            lane_en;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic                  unused_addr;

    assign is_io       = (dmAddress[31:16] == IO_BASE[31:16]);
    assign ram_idx     = dmAddress[ADDR_WIDTH+1:2];
    assign ram_we      = dmWrite && !is_io && !align_err;
    assign io_we       = dmWrite && is_io && !align_err;
    assign push        = io_we && (dmAddress[3:2] == 2'd0);
    assign status_wr   = io_we && (dmAddress[3:2] == 2'd1);
    assign unused_addr = ^dmAddress;

    // Reserved size encodings are treated as misaligned so they never touch state.
    always_comb begin
        case (dmFunc3)
            3'd0, 3'd4: align_err = 1'b0;
            3'd1, 3'd5: align_err = dmAddress[0];
            3'd2:       align_err = |dmAddress[1:0];
            default:    align_err = 1'b1;
        endcase
    end

    always_comb begin
        lane_en = 4'b1111;
        wr_data = dmDataOut;
        case (dmFunc3[1:0])
            2'd0: begin
                lane_en = 4'b0001 << dmAddress[1:0];
                wr_data = {4{dmDataOut[7:0]}};
            end
            2'd1: begin
                lane_en = dmAddress[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{dmDataOut[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_data = dmDataOut;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        rd_word <= mem[ram_idx];
    end

    // Load selectors ride alongside the RAM read; r_gate holds the output at 0
    // until the first edge after reset, since rd_word itself is not reset.
    logic        r_gate;
    logic [1:0]  r_off;
    logic [2:0]  r_func3;
    logic        r_io;
    logic        r_err;
    logic [31:0] r_io_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_gate     <= 1'b0;
            r_off      <= 2'd0;
            r_func3    <= 3'd0;
            r_io       <= 1'b0;
            r_err      <= 1'b0;
            r_io_rdata <= 32'd0;
        end else begin
            r_gate     <= 1'b1;
            r_off      <= dmAddress[1:0];
            r_func3    <= dmFunc3;
            r_io       <= is_io;
            r_err      <= align_err;
            r_io_rdata <= (dmAddress[3:2] == 2'd1) ?
                          {29'd0, misaligned, overflow, fifo_full} : 32'd0;
        end
    end

    logic [31:0] src_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        src_word = r_io ? r_io_rdata : rd_word;
        case (r_off)
            2'd0:    ld_byte = src_word[7:0];
            2'd1:    ld_byte = src_word[15:8];
            2'd2:    ld_byte = src_word[23:16];
            default: ld_byte = src_word[31:24];
        endcase
        ld_half = r_off[1] ? src_word[31:16] : src_word[15:0];
        case (r_func3)
            3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {24'd0, ld_byte};
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_ext = {16'd0, ld_half};
            3'd2:    ld_ext = src_word;
            default: ld_ext = 32'd0;
        endcase
        dmDataIn = (r_gate && !r_err) ? ld_ext : 32'd0;
    end

    // A STATUS clear wins over a set arriving in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misaligned <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (status_wr && dmDataOut[2]) misaligned <= 1'b0;
            else if (align_err)            misaligned <= 1'b1;
            if (status_wr && dmDataOut[1])          overflow <= 1'b0;
            else if (push && fifo_full && !pop)     overflow <= 1'b1;
        end
    end

    logic [7:0] fifo_mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign fifo_full = (count == 2'd2);
    assign ioValid   = (count != 2'd0);
    assign pop       = ioValid && ioReady;
    assign push_ok   = push && (!fifo_full || pop);
    assign ioData    = ioValid ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr] <= dmDataOut[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_rv32_data_memory.sv
// Scoreboard bench for rv32_data_memory: directed stores/loads and FIFO traffic,
// with a negedge monitor popping expected load and drain values.
module tb_rv32_data_memory;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dmAddress;
    logic [2:0]  dmFunc3;
    logic        dmWrite;
    logic [31:0] dmDataOut;
    logic [31:0] dmDataIn;
    logic [7:0]  ioData;
    logic        ioValid;
    logic        ioReady;
    logic        misaligned;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] load_q [$];
    logic [7:0]  io_q [$];
    logic        ld_issue = 1'b0;
    logic        ld_pend  = 1'b0;

    localparam logic [31:0] IO_TX = 32'hFFFF_0000;
    localparam logic [31:0] IO_ST = 32'hFFFF_0004;

    rv32_data_memory dut (
        .clock      (clock),
        .reset      (reset),
        .dmAddress  (dmAddress),
        .dmFunc3    (dmFunc3),
        .dmWrite    (dmWrite),
        .dmDataOut  (dmDataOut),
        .dmDataIn   (dmDataIn),
        .ioData     (ioData),
        .ioValid    (ioValid),
        .ioReady    (ioReady),
        .misaligned (misaligned),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic setIdle();
        dmAddress = 32'd0;
        dmFunc3   = 3'd2;
        dmWrite   = 1'b0;
        dmDataOut = 32'd0;
        ld_issue  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] f3,
                                 input logic wr, input logic [31:0] data,
                                 input logic [31:0] exp_load);
        dmAddress = addr;
        dmFunc3   = f3;
        dmWrite   = wr;
        dmDataOut = data;
        if (!wr) begin
            load_q.push_back(exp_load);
            ld_issue = 1'b1;
        end else begin
            ld_issue = 1'b0;
        end
        @(posedge clock);
        #1;
        setIdle();
    endtask

    task automatic store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        applyStimulus(addr, f3, 1'b1, data, 32'd0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] expv);
        applyStimulus(addr, f3, 1'b0, 32'd0, expv);
    endtask

    task automatic drainWait();
        for (int i = 0; i < 8 && ioValid; i++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("drain_done_ioValid", {31'd0, ioValid}, 32'd0);
        checkOutput("drain_queue_left", io_q.size(), 32'd0);
    endtask

    always @(posedge clock) ld_pend <= ld_issue;

    // Monitor: compares load results and drained bytes against the scoreboard.
    always @(negedge clock) begin
        if (ld_pend) begin
            if (load_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL load_unexpected: got 0x%08h, expected no load", dmDataIn);
            end else begin
                checkOutput("load_data", dmDataIn, load_q.pop_front());
            end
        end
        if (ioValid && ioReady) begin
            if (io_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL drain_unexpected: got 0x%02h, expected no byte", ioData);
            end else begin
                checkOutput("drain_data", {24'd0, ioData}, {24'd0, io_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setIdle();
        ioReady = 1'b0;
        #2;
        checkOutput("reset_dmDataIn", dmDataIn, 32'd0);
        checkOutput("reset_ioValid", {31'd0, ioValid}, 32'd0);
        checkOutput("reset_ioData", {24'd0, ioData}, 32'd0);
        checkOutput("reset_misaligned", {31'd0, misaligned}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] store/load lanes");
        store(32'h10, 3'd2, 32'h8000_00F1);
        load(32'h10, 3'd0, 32'hFFFF_FFF1);
        load(32'h10, 3'd4, 32'h0000_00F1);
        load(32'h12, 3'd1, 32'hFFFF_8000);
        load(32'h12, 3'd5, 32'h0000_8000);
        load(32'h10, 3'd2, 32'h8000_00F1);

        $display("[TB] partial stores");
        store(32'h20, 3'd2, 32'h1122_3344);
        store(32'h21, 3'd0, 32'h0000_00AA);
        store(32'h22, 3'd1, 32'h0000_BEEF);
        load(32'h20, 3'd2, 32'hBEEF_AA44);
        load(32'h21, 3'd0, 32'hFFFF_FFAA);

        $display("[TB] misaligned accesses");
        store(32'h30, 3'd2, 32'h0);
        checkOutput("aligned_no_flag", {31'd0, misaligned}, 32'd0);
        store(32'h31, 3'd2, 32'hDEAD_BEEF);
        checkOutput("misaligned_set", {31'd0, misaligned}, 32'd1);
        load(32'h30, 3'd2, 32'h0);
        load(32'h33, 3'd1, 32'h0);
        load(32'h20, 3'd3, 32'h0);
        load(IO_ST, 3'd2, 32'h4);
        store(IO_ST, 3'd2, 32'h4);
        checkOutput("misaligned_cleared", {31'd0, misaligned}, 32'd0);

        $display("[TB] fifo fill and overflow");
        io_q.push_back(8'h41);
        io_q.push_back(8'h42);
        store(IO_TX, 3'd2, 32'h41);
        checkOutput("push_ioValid", {31'd0, ioValid}, 32'd1);
        checkOutput("push_ioData", {24'd0, ioData}, 32'h41);
        store(IO_TX, 3'd2, 32'h42);
        store(IO_TX, 3'd2, 32'h43);
        checkOutput("overflow_set", {31'd0, overflow}, 32'd1);
        load(IO_ST, 3'd2, 32'h3);
        load(IO_TX, 3'd2, 32'h0);
        ioReady = 1'b1;
        drainWait();
        ioReady = 1'b0;
        store(IO_ST, 3'd2, 32'h2);
        checkOutput("overflow_cleared", {31'd0, overflow}, 32'd0);

        $display("[TB] full push plus pop");
        io_q.push_back(8'h41);
        io_q.push_back(8'h42);
        io_q.push_back(8'h43);
        store(IO_TX, 3'd2, 32'h41);
        store(IO_TX, 3'd2, 32'h42);
        ioReady = 1'b1;
        store(IO_TX, 3'd2, 32'h43);
        checkOutput("pushpop_no_overflow", {31'd0, overflow}, 32'd0);
        drainWait();
        ioReady = 1'b0;

        $display("[TB] async reset");
        store(IO_TX, 3'd2, 32'h55);
        store(IO_TX, 3'd2, 32'h66);
        load(32'h22, 3'd2, 32'h0);
        checkOutput("pre_reset_misaligned", {31'd0, misaligned}, 32'd1);
        checkOutput("pre_reset_ioValid", {31'd0, ioValid}, 32'd1);
        load(32'h20, 3'd2, 32'hBEEF_AA44);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_ioValid", {31'd0, ioValid}, 32'd0);
        checkOutput("async_ioData", {24'd0, ioData}, 32'd0);
        checkOutput("async_misaligned", {31'd0, misaligned}, 32'd0);
        checkOutput("async_dmDataIn", dmDataIn, 32'd0);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        load(32'h20, 3'd2, 32'hBEEF_AA44);
        checkOutput("post_reset_ioValid", {31'd0, ioValid}, 32'd0);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("load_queue_left", load_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
